// File: rtl/dpram_pkg.sv
// Shared constants and types for the variable-node LLR vector RAM.
// A word packs eight 3-bit LLRs, LLR0 in the top bits down to LLR7 in [2:0].
package dpram_pkg;

    localparam int LLR_W        = 3;
    localparam int LLR_PER_WORD = 8;
    localparam int DATA_W       = LLR_W * LLR_PER_WORD;
    localparam int ADDR_W       = 5;
    localparam int DEPTH        = 32;

    typedef logic [DATA_W-1:0] llr_vec_t;

    localparam llr_vec_t LLR_VEC_ZERO = '0;

endpackage

// File: rtl/dpram_32x24.sv
// Simple dual-port flop RAM (one write, one registered read port) for LLR vectors.
// Define DPRAM_WR_BYPASS_EN for write-first forwarding on same-address collisions.
module dpram_32x24
    import dpram_pkg::LLR_VEC_ZERO;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata_p1;
    logic [DATA_W-1:0] w_rd_word_p0;

`ifdef DPRAM_WR_BYPASS_EN
    logic w_collide_p0;
    assign w_collide_p0 = we && (waddr == raddr);
    assign w_rd_word_p0 = w_collide_p0 ? wdata : r_mem[raddr];
`else
    // Plain array read gives the pre-write word on a collision.
    assign w_rd_word_p0 = r_mem[raddr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(LLR_VEC_ZERO);
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // p0 -> p1: registered read; holds its value while re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_p1 <= DATA_W'(LLR_VEC_ZERO);
        end else if (re) begin
            r_rdata_p1 <= w_rd_word_p0;
        end
    end

    assign rdata = r_rdata_p1;

endmodule

// File: tb/tb_dpram_32x24.sv
// Directed bench for dpram_32x24: array-based reference model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_dpram_32x24;
    import dpram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [23:0] wdata = '0;
    logic        re = 1'b0;
    logic [4:0]  raddr = '0;
    logic [23:0] rdata;

    int n_pass  = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    llr_vec_t mdl_mem [32];
    llr_vec_t mdl_rdata;

    dpram_32x24 #(.DATA_W(24), .ADDR_W(5), .DEPTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

`ifdef DPRAM_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Reference: a RAM array and a read register, updated from the current inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mdl_mem[i]) mdl_mem[i] = '0;
            mdl_rdata = '0;
        end else begin
            if (re) begin
                if (BYPASS && we && waddr == raddr) mdl_rdata = wdata;
                else mdl_rdata = mdl_mem[raddr];
            end
            if (we) mdl_mem[waddr] = wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_total++;
            if (rdata === mdl_rdata) n_pass++;
            else $display("FAIL model_cmp t=%0t rdata=%h expected=%h", $time, rdata, mdl_rdata);
        end
    end

    task automatic check_lit(input string name, input logic [23:0] exp);
        n_total++;
        if (rdata === exp) n_pass++;
        else $display("FAIL %s rdata=%h expected=%h", name, rdata, exp);
    endtask

    task automatic cyc(input logic w, input logic [4:0] wa, input logic [23:0] wd,
                       input logic r, input logic [4:0] ra);
        we = w; waddr = wa; wdata = wd; re = r; raddr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 24'h0, 1'b0, 5'd0);
    endtask

    logic [23:0] exp_col;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_lit("reset_state", 24'h000000);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Fill a few words, then reset mid-stream with a write in flight.
        cyc(1'b1, 5'd0,  24'hAAAAAA, 1'b0, 5'd0);
        cyc(1'b1, 5'd17, 24'hBBBBBB, 1'b0, 5'd0);
        cyc(1'b1, 5'd31, 24'hCCCCCC, 1'b1, 5'd0);
        check_lit("pre_reset_rd0", 24'hAAAAAA);
        we = 1'b1; waddr = 5'd17; wdata = 24'hDDDDDD; re = 1'b1; raddr = 5'd31;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_lit("reset_mid", 24'h000000);
        idle();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 5'd0, 24'h0, 1'b1, 5'd0);
        check_lit("post_reset_rd0", 24'h000000);
        cyc(1'b0, 5'd0, 24'h0, 1'b1, 5'd17);
        check_lit("post_reset_rd17", 24'h000000);
        cyc(1'b0, 5'd0, 24'h0, 1'b1, 5'd31);
        check_lit("post_reset_rd31", 24'h000000);

        // Write then read next cycle.
        cyc(1'b1, 5'd5, 24'o01121223, 1'b0, 5'd0);
        cyc(1'b0, 5'd0, 24'h0, 1'b1, 5'd5);
        check_lit("wr_rd_5", 24'o01121223);

        // Hold while re is low, even as address 5 is overwritten.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 5'd5, 24'o77777777, 1'b0, 5'd5);
            check_lit("hold_5", 24'o01121223);
        end
        cyc(1'b0, 5'd0, 24'h0, 1'b1, 5'd5);
        check_lit("after_hold_5", 24'o77777777);

        // Same-address collision.
        cyc(1'b1, 5'd9, 24'h123456, 1'b0, 5'd0);
        cyc(1'b1, 5'd9, 24'hABCDEF, 1'b1, 5'd9);
        exp_col = BYPASS ? 24'hABCDEF : 24'h123456;
        check_lit("collision_9", exp_col);
        cyc(1'b0, 5'd0, 24'h0, 1'b1, 5'd9);
        check_lit("after_collision_9", 24'hABCDEF);

        // Full sweep, read back in reverse order.
        for (int a = 0; a < 32; a++) begin
            cyc(1'b1, 5'(a), 24'(a) * 24'h010101, 1'b0, 5'd0);
        end
        for (int a = 31; a >= 0; a--) begin
            cyc(1'b0, 5'd0, 24'h0, 1'b1, 5'(a));
            check_lit("sweep", 24'(a) * 24'h010101);
        end
        check_lit("sweep_last_is_0", 24'h000000);
        cyc(1'b0, 5'd0, 24'h0, 1'b1, 5'd31);
        check_lit("sweep_31", 24'h1F1F1F);

        // Concurrent accesses at different addresses.
        cyc(1'b1, 5'd3, 24'h5A5A5A, 1'b1, 5'd4);
        check_lit("concurrent_rd4", 24'h040404);
        cyc(1'b0, 5'd0, 24'h0, 1'b1, 5'd3);
        check_lit("concurrent_wr3", 24'h5A5A5A);

        idle();
        idle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
